// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : seg_pkg
//  Purpose  : Shared constants and polarity helpers for the segment scan
//             multiplexer. A pattern bit is always 1 = lit internally; the
//             helpers apply the board polarity at the pins.
//  Contents : NUM_DIGITS, SEG_W, seg_pol(), an_pol(), seg_all_off(),
//             an_all_off()
//  Revision : 1.0 - initial release
// ============================================================================
package seg_pkg;

    localparam int NUM_DIGITS = 6;
    localparam int SEG_W      = 7;

    // Polarity mux for the segment bus: invert for common-anode boards.
    function automatic logic [SEG_W-1:0] seg_pol(input logic [SEG_W-1:0] pattern,
                                                 input logic              active_low);
        return active_low ? ~pattern : pattern;
    endfunction

    // Polarity mux for the digit enables.
    function automatic logic [NUM_DIGITS-1:0] an_pol(input logic [NUM_DIGITS-1:0] pattern,
                                                     input logic                  active_low);
        return active_low ? ~pattern : pattern;
    endfunction

    // Pin value with every segment dark.
    function automatic logic [SEG_W-1:0] seg_all_off(input logic active_low);
        return seg_pol('0, active_low);
    endfunction

    // Pin value with every digit disabled.
    function automatic logic [NUM_DIGITS-1:0] an_all_off(input logic active_low);
        return an_pol('0, active_low);
    endfunction

endpackage
`default_nettype wire

// File: rtl/scan_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module   : scan_tick_gen
//  Purpose  : Digit-slot prescaler. Counts 0..TICK_DIV-1 and wraps.
//  Ports    : clk, rst        - clock, synchronous active-high reset
//             slot_wrap (out) - high on the last cycle of every slot
//             in_gap    (out) - high during the first BLANK_CYC cycles of a slot
//  Revision : 1.0 - initial release
// ============================================================================
module scan_tick_gen #(
    parameter int TICK_DIV  = 50000,
    parameter int BLANK_CYC = 16
) (
    input  logic clk,
    input  logic rst,
    output logic slot_wrap,
    output logic in_gap
);

    localparam int               DIV_W      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] C_DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [DIV_W-1:0] C_GAP_END  = DIV_W'(BLANK_CYC);

    logic [DIV_W-1:0] r_div;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div <= '0;
        end else if (r_div == C_DIV_LAST) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    assign slot_wrap = (r_div == C_DIV_LAST);
    assign in_gap    = (r_div <  C_GAP_END);

endmodule
`default_nettype wire

// File: rtl/seg_scan_mux.sv
`default_nettype none
// ============================================================================
//  Module   : seg_scan_mux
//  Purpose  : Time-multiplexes six 7-segment patterns onto one segment bus
//             with six digit enables. All digits are snapshotted together at
//             frame boundaries so a frame never mixes old and new data. Each
//             slot begins with a blanking gap to suppress ghosting.
//  Ports    : clk, rst          - clock, synchronous active-high reset
//             d1..d6      (in)  - digit 0..5 patterns, bit6..0 = g..a, 1 = lit
//             hold        (in)  - freeze the snapshot
//             blank       (in)  - force all digit enables off
//             seg         (out) - shared segment bus (board polarity)
//             an          (out) - digit enables, an[k] = digit k
//             frame_start (out) - one-cycle pulse marking a snapshot load
//  Revision : 1.0 - initial release
// ============================================================================
module seg_scan_mux
    import seg_pkg::*;
#(
    parameter int TICK_DIV   = 50000,
    parameter int BLANK_CYC  = 16,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [SEG_W-1:0]      d1,
    input  logic [SEG_W-1:0]      d2,
    input  logic [SEG_W-1:0]      d3,
    input  logic [SEG_W-1:0]      d4,
    input  logic [SEG_W-1:0]      d5,
    input  logic [SEG_W-1:0]      d6,
    input  logic                  hold,
    input  logic                  blank,
    output logic [SEG_W-1:0]      seg,
    output logic [NUM_DIGITS-1:0] an,
    output logic                  frame_start
);

    localparam logic [SEG_W-1:0]      C_SEG_OFF  = seg_all_off(ACTIVE_LOW);
    localparam logic [NUM_DIGITS-1:0] C_AN_OFF   = an_all_off(ACTIVE_LOW);
    localparam logic [2:0]            C_IDX_LAST = 3'(NUM_DIGITS - 1);

    logic                  w_slot_wrap;
    logic                  w_in_gap;
    logic                  w_frame_end;
    logic                  w_load;
    logic [SEG_W-1:0]      w_cur;
    logic [NUM_DIGITS-1:0] w_onehot;

    logic [2:0]            r_idx;
    logic                  r_load_pending;
    logic [SEG_W-1:0]      r_snap [NUM_DIGITS];
    logic [SEG_W-1:0]      r_seg;
    logic [NUM_DIGITS-1:0] r_an;
    logic                  r_frame_start;

    scan_tick_gen #(
        .TICK_DIV  (TICK_DIV),
        .BLANK_CYC (BLANK_CYC)
    ) u_tick (
        .clk       (clk),
        .rst       (rst),
        .slot_wrap (w_slot_wrap),
        .in_gap    (w_in_gap)
    );

    // Digit index; the out-of-range values recover to digit 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx <= '0;
        end else if (r_idx > C_IDX_LAST) begin
            r_idx <= '0;
        end else if (w_slot_wrap) begin
            r_idx <= (r_idx == C_IDX_LAST) ? 3'd0 : r_idx + 3'd1;
        end
    end

    // A frame boundary loads the snapshot unless held. The pending flag is set
    // only by reset so the first frame shows live data even if hold was up.
    assign w_frame_end = w_slot_wrap && (r_idx == C_IDX_LAST);
    assign w_load      = !hold && (w_frame_end || r_load_pending);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_load_pending <= 1'b1;
            for (int k = 0; k < NUM_DIGITS; k++) begin
                r_snap[k] <= '0;
            end
        end else if (w_load) begin
            r_load_pending <= 1'b0;
            r_snap[0]      <= d1;
            r_snap[1]      <= d2;
            r_snap[2]      <= d3;
            r_snap[3]      <= d4;
            r_snap[4]      <= d5;
            r_snap[5]      <= d6;
        end
    end

    always_comb begin
        w_cur = '0;
        case (r_idx)
            3'd0:    w_cur = r_snap[0];
            3'd1:    w_cur = r_snap[1];
            3'd2:    w_cur = r_snap[2];
            3'd3:    w_cur = r_snap[3];
            3'd4:    w_cur = r_snap[4];
            3'd5:    w_cur = r_snap[5];
            default: w_cur = '0;
        endcase
    end

    // An illegal idx shifts the bit out, leaving every digit disabled.
    assign w_onehot = NUM_DIGITS'(1) << r_idx;

    // Output stage runs one cycle behind div/idx. The segment bus is not
    // blanked in the gap; the enables alone decide whether anything lights.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_seg         <= C_SEG_OFF;
            r_an          <= C_AN_OFF;
            r_frame_start <= 1'b0;
        end else begin
            r_seg         <= seg_pol(w_cur, ACTIVE_LOW);
            r_an          <= (blank || w_in_gap) ? C_AN_OFF : an_pol(w_onehot, ACTIVE_LOW);
            r_frame_start <= w_load;
        end
    end

    assign seg         = r_seg;
    assign an          = r_an;
    assign frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_mux.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seg_scan_mux
//  Purpose  : Self-checking bench. Runs an active-low and an active-high
//             instance side by side against a cycle-arithmetic reference
//             model (slot = cycle/TICK_DIV, phase = cycle%TICK_DIV).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seg_scan_mux;

    localparam int T = 8;
    localparam int B = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] d [6];
    logic       hold;
    logic       blank;

    logic [6:0] al_seg, ah_seg;
    logic [5:0] al_an, ah_an;
    logic       al_fs, ah_fs;

    int checks = 0;
    int passed = 0;

    // Reference model state
    int         m_n;
    bit         m_pending;
    logic [6:0] m_snap [6];

    always #5 clk = ~clk;

    seg_scan_mux #(.TICK_DIV(T), .BLANK_CYC(B), .ACTIVE_LOW(1'b1)) u_al (
        .clk(clk), .rst(rst),
        .d1(d[0]), .d2(d[1]), .d3(d[2]), .d4(d[3]), .d5(d[4]), .d6(d[5]),
        .hold(hold), .blank(blank),
        .seg(al_seg), .an(al_an), .frame_start(al_fs)
    );

    seg_scan_mux #(.TICK_DIV(T), .BLANK_CYC(B), .ACTIVE_LOW(1'b0)) u_ah (
        .clk(clk), .rst(rst),
        .d1(d[0]), .d2(d[1]), .d3(d[2]), .d4(d[3]), .d5(d[4]), .d6(d[5]),
        .hold(hold), .blank(blank),
        .seg(ah_seg), .an(ah_an), .frame_start(ah_fs)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, m_n, obs, exp);
    endtask

    // One clock: predict from the rules, advance, then compare both DUTs.
    task automatic step();
        logic [6:0] ls;
        logic [5:0] la;
        logic       lf;
        logic [6:0] inv_s;
        logic [5:0] inv_a;
        int         dv;
        int         ix;
        bit         ld;
        if (rst) begin
            ls = '0; la = '0; lf = 1'b0;
            m_n = 0; m_pending = 1'b1;
            for (int k = 0; k < 6; k++) m_snap[k] = '0;
        end else begin
            dv = m_n % T;
            ix = (m_n / T) % 6;
            ld = !hold && (m_pending || (dv == T - 1 && ix == 5));
            ls = m_snap[ix];
            la = (blank || dv < B) ? 6'd0 : 6'(1 << ix);
            lf = ld;
            if (ld) begin
                for (int k = 0; k < 6; k++) m_snap[k] = d[k];
                m_pending = 1'b0;
            end
            m_n++;
        end
        @(posedge clk);
        #1;
        inv_s = ~ls;
        inv_a = ~la;
        chk("al_seg", {1'b0, al_seg}, {1'b0, inv_s});
        chk("al_an",  {2'b0, al_an},  {2'b0, inv_a});
        chk("al_fs",  {7'b0, al_fs},  {7'b0, lf});
        chk("ah_seg", {1'b0, ah_seg}, {1'b0, ls});
        chk("ah_an",  {2'b0, ah_an},  {2'b0, la});
        chk("ah_fs",  {7'b0, ah_fs},  {7'b0, lf});
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        rst = 1'b1; hold = 1'b0; blank = 1'b0;
        d[0] = 7'h3F; d[1] = 7'h06; d[2] = 7'h5B;
        d[3] = 7'h4F; d[4] = 7'h66; d[5] = 7'h6D;
        m_n = 0; m_pending = 1'b1;
        for (int k = 0; k < 6; k++) m_snap[k] = '0;

        // Reset held three cycles: all-off outputs, no pulse.
        run(3);

        // Release: first cycle loads, then two full frames of scanning.
        rst = 1'b0;
        run(2 * 6 * T);

        // Mid-slot-1 change to digit 2 must wait for the next frame.
        run(T + 3);
        d[2] = 7'h7F;
        run(2 * 6 * T);

        // Hold across a boundary with fresh inputs, then release it.
        run(2 * T);
        hold = 1'b1;
        for (int k = 0; k < 6; k++) d[k] = 7'($urandom);
        run(6 * T);
        hold = 1'b0;
        run(6 * T + 4);

        // Blank for 20 cycles; counters keep running underneath.
        blank = 1'b1;
        run(20);
        blank = 1'b0;
        run(6 * T);

        // Reset in the middle of slot 3.
        for (int i = 0; i < 6 * T; i++) begin
            if ((m_n / T) % 6 == 3 && m_n % T == 4) break;
            step();
        end
        rst = 1'b1;
        run(2);
        rst = 1'b0;
        run(6 * T + 2);

        // Hold asserted while the post-reset load is still pending.
        rst = 1'b1;
        run(1);
        rst = 1'b0;
        hold = 1'b1;
        run(5);
        hold = 1'b0;
        run(6 * T);

        // Randomised traffic on digits, hold and blank.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(7, 0) == 0) d[$urandom_range(5, 0)] = 7'($urandom);
            if ($urandom_range(31, 0) == 0) hold  = ~hold;
            if ($urandom_range(15, 0) == 0) blank = ~blank;
            step();
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire
